// File: rtl/pipe_pc_select_if.sv
// rtl/pipe_pc_select_if.sv - fetch / M-stage / W-stage signal bundle for the PC-select unit
interface pipe_pc_select_if #(
  parameter int ADDR_W = 64,
  parameter int CNT_W  = 16
);
  logic [3:0]        f_icode;
  logic [ADDR_W-1:0] f_valC;
  logic [ADDR_W-1:0] f_valP;
  logic              F_stall;
  logic [3:0]        M_icode;
  logic              M_cnd;
  logic              M_pred_taken;
  logic [ADDR_W-1:0] M_altPC;
  logic [3:0]        W_icode;
  logic [ADDR_W-1:0] W_valM;
  logic [ADDR_W-1:0] f_pc;
  logic              f_pc_valid;
  logic              f_pred_taken;
  logic              mispredict;
  logic              halted;
  logic [CNT_W-1:0]  mispredict_cnt;

  modport master (
    output f_icode, f_valC, f_valP, F_stall,
    output M_icode, M_cnd, M_pred_taken, M_altPC,
    output W_icode, W_valM,
    input  f_pc, f_pc_valid, f_pred_taken, mispredict, halted, mispredict_cnt
  );

  modport slave (
    input  f_icode, f_valC, f_valP, F_stall,
    input  M_icode, M_cnd, M_pred_taken, M_altPC,
    input  W_icode, W_valM,
    output f_pc, f_pc_valid, f_pred_taken, mispredict, halted, mispredict_cnt
  );
endinterface

// File: rtl/pipe_pc_select.sv
// rtl/pipe_pc_select.sv - pipelined Y86 PC select/predict with mispredict and ret recovery
// BTFNT_PRED_EN selects backward-taken/forward-not-taken prediction instead of always-taken.
module pipe_pc_select #(
  parameter int                ADDR_W   = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                CNT_W    = 16
) (
  input logic         clk,
  input logic         rst_n,
  pipe_pc_select_if.slave bus
);
  localparam logic [3:0] I_HALT = 4'h0;
  localparam logic [3:0] I_JXX  = 4'h7;
  localparam logic [3:0] I_CALL = 4'h8;
  localparam logic [3:0] I_RET  = 4'h9;

  typedef enum logic [1:0] {RUN = 2'd0, RET_WAIT = 2'd1, HALTED = 2'd2} state_t;

  state_t            state;
  state_t            state_next;
  state_t            fetched_state;
  logic [ADDR_W-1:0] pred_pc;
  logic [ADDR_W-1:0] prediction;
  logic [ADDR_W-1:0] pc_sel;
  logic [CNT_W-1:0]  cnt;
  logic              mispredict;
  logic              w_ret;
  logic              redirect;
  logic              pred_taken;
  logic              pc_valid;
  logic              in_run;
  logic              in_halted;

  assign mispredict = (bus.M_icode == I_JXX) && (bus.M_cnd != bus.M_pred_taken);
  // A W-stage ret arriving alongside a mispredict belongs to the squashed path.
  assign w_ret      = (bus.W_icode == I_RET) && !mispredict;
  assign redirect   = mispredict || w_ret;

`ifdef BTFNT_PRED_EN
  assign pred_taken = bus.f_valC < bus.f_valP;
`else
  assign pred_taken = 1'b1;
`endif

  always_comb begin
    pc_sel = pred_pc;
    if (mispredict)
      pc_sel = bus.M_altPC;
    else if (w_ret)
      pc_sel = bus.W_valM;
  end

  always_comb begin
    prediction = bus.f_valP;
    if (bus.f_icode == I_CALL)
      prediction = bus.f_valC;
    else if (bus.f_icode == I_JXX && pred_taken)
      prediction = bus.f_valC;
  end

  always_comb begin
    fetched_state = RUN;
    if (bus.f_icode == I_RET)
      fetched_state = RET_WAIT;
    else if (bus.f_icode == I_HALT)
      fetched_state = HALTED;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      pred_pc <= RESET_PC;
    else if (pc_valid && (!bus.F_stall || redirect))
      pred_pc <= prediction;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      cnt <= '0;
    else if (mispredict && !(&cnt))
      cnt <= cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      state <= RUN;
    else
      state <= state_next;
  end

  // HALTED ignores a lone W ret; only a mispredict (or reset) brings it back.
  always_comb begin
    state_next = state;
    if (mispredict || (w_ret && state != HALTED) || (state == RUN && !bus.F_stall))
      state_next = fetched_state;
  end

  always_comb begin
    in_run    = 1'b0;
    in_halted = 1'b0;
    case (state)
      RUN:     in_run    = 1'b1;
      HALTED:  in_halted = 1'b1;
      default: ;
    endcase
  end

  assign pc_valid = redirect || in_run;

  assign bus.f_pc           = pc_sel;
  assign bus.f_pc_valid     = pc_valid;
  assign bus.f_pred_taken   = pred_taken;
  assign bus.mispredict     = mispredict;
  assign bus.halted         = in_halted;
  assign bus.mispredict_cnt = cnt;
endmodule

// File: tb/tb_pipe_pc_select.sv
// tb/tb_pipe_pc_select.sv - directed and randomized checks of pipe_pc_select against a behavioural model
module tb_pipe_pc_select;
  localparam int          AW       = 64;
  localparam int          CW       = 2;
  localparam logic [63:0] RPC      = 64'h100;
  localparam int          CNT_MAX  = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  pipe_pc_select_if #(.ADDR_W(AW), .CNT_W(CW)) bus ();

  pipe_pc_select #(.ADDR_W(AW), .RESET_PC(RPC), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: mode 0 = fetching, 1 = waiting for ret, 2 = halted.
  logic [63:0] m_pred;
  int          m_mode;
  int          m_cnt;
  bit          m_ready = 0;

  function automatic int mode_for(input logic [3:0] ic);
    if (ic == 4'h9) return 1;
    if (ic == 4'h0) return 2;
    return 0;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      m_pred  = RPC;
      m_mode  = 0;
      m_cnt   = 0;
      m_ready = 1;
    end else if (m_ready) begin
      bit          mp, wret, valid, pt;
      logic [63:0] pc, guess;
      mp    = (bus.M_icode == 4'h7) && (bus.M_cnd != bus.M_pred_taken);
      wret  = !mp && (bus.W_icode == 4'h9);
      pc    = mp ? bus.M_altPC : (wret ? bus.W_valM : m_pred);
      valid = mp || wret || (m_mode == 0);
`ifdef BTFNT_PRED_EN
      pt = bus.f_valC < bus.f_valP;
`else
      pt = 1'b1;
`endif
      if (bus.f_icode == 4'h8 || (bus.f_icode == 4'h7 && pt)) guess = bus.f_valC;
      else guess = bus.f_valP;

      chk("m_f_pc", bus.f_pc, pc);
      chk("m_valid", 64'(bus.f_pc_valid), 64'(valid));
      chk("m_pred_taken", 64'(bus.f_pred_taken), 64'(pt));
      chk("m_mispredict", 64'(bus.mispredict), 64'(mp));
      chk("m_halted", 64'(bus.halted), 64'(m_mode == 2));
      chk("m_cnt", 64'(bus.mispredict_cnt), 64'(m_cnt));

      if (valid && (!bus.F_stall || mp || wret)) m_pred = guess;
      if (mp) m_mode = mode_for(bus.f_icode);
      else if (wret && m_mode != 2) m_mode = mode_for(bus.f_icode);
      else if (m_mode == 0 && !bus.F_stall) m_mode = mode_for(bus.f_icode);
      if (mp && m_cnt < CNT_MAX) m_cnt++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.f_icode = 4'h1; bus.f_valC = '0; bus.f_valP = '0; bus.F_stall = 1'b0;
    bus.M_icode = 4'h1; bus.M_cnd = 1'b0; bus.M_pred_taken = 1'b0; bus.M_altPC = '0;
    bus.W_icode = 4'h1; bus.W_valM = '0;
  endtask

  task automatic set_mispredict(input logic [63:0] alt);
    bus.M_icode = 4'h7; bus.M_cnd = 1'b0; bus.M_pred_taken = 1'b1; bus.M_altPC = alt;
  endtask

  function automatic logic [3:0] rnd_icode();
    case ($urandom_range(0, 15))
      0:       return 4'h0;
      1, 2:    return 4'h9;
      3, 4, 5: return 4'h7;
      6:       return 4'h8;
      default: return 4'($urandom_range(1, 6));
    endcase
  endfunction

  initial begin
    idle();
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    #1;
    chk("rst_f_pc", bus.f_pc, 64'h100);
    chk("rst_valid", 64'(bus.f_pc_valid), 64'd1);
    chk("rst_cnt", 64'(bus.mispredict_cnt), 64'd0);
    chk("rst_halted", 64'(bus.halted), 64'd0);
    chk("rst_mispredict", 64'(bus.mispredict), 64'd0);

    bus.f_icode = 4'h1; bus.f_valP = 64'h102; bus.F_stall = 1'b1;
    step();
    chk("stall_hold", bus.f_pc, 64'h100);
    bus.F_stall = 1'b0;
    step();
    chk("seq_next", bus.f_pc, 64'h102);

    bus.f_icode = 4'h7; bus.f_valC = 64'h200; bus.f_valP = 64'h10A;
    #1;
`ifdef BTFNT_PRED_EN
    chk("jxx_pt", 64'(bus.f_pred_taken), 64'd0);
    step();
    chk("jxx_target", bus.f_pc, 64'h10A);
`else
    chk("jxx_pt", 64'(bus.f_pred_taken), 64'd1);
    step();
    chk("jxx_target", bus.f_pc, 64'h200);
`endif
    bus.f_icode = 4'h1; bus.f_valP = 64'h10C;
    set_mispredict(64'h10A);
    #1;
    chk("mp_f_pc", bus.f_pc, 64'h10A);
    chk("mp_flag", 64'(bus.mispredict), 64'd1);
    step();
    bus.M_icode = 4'h1;
    #1;
    chk("mp_cnt1", 64'(bus.mispredict_cnt), 64'd1);
    chk("mp_after", bus.f_pc, 64'h10C);

    bus.f_icode = 4'h9; bus.f_valP = 64'h10D;
    step();
    bus.f_icode = 4'h1; bus.f_valP = 64'h999;
    #1;
    chk("ret_wait_valid0", 64'(bus.f_pc_valid), 64'd0);
    step();
    chk("ret_wait_valid0b", 64'(bus.f_pc_valid), 64'd0);
    bus.W_icode = 4'h9; bus.W_valM = 64'h3F0; bus.f_valP = 64'h3F2;
    #1;
    chk("ret_f_pc", bus.f_pc, 64'h3F0);
    chk("ret_valid", 64'(bus.f_pc_valid), 64'd1);
    step();
    bus.W_icode = 4'h1;
    #1;
    chk("ret_after", bus.f_pc, 64'h3F2);

    bus.f_icode = 4'h7; bus.f_valC = 64'h500; bus.f_valP = 64'h3FB;
    step();
    bus.f_icode = 4'h0;
    step();
    bus.f_icode = 4'h1;
    #1;
    chk("halt_flag", 64'(bus.halted), 64'd1);
    chk("halt_valid0", 64'(bus.f_pc_valid), 64'd0);
    set_mispredict(64'h150);
    bus.W_icode = 4'h9; bus.W_valM = 64'h777; bus.f_valP = 64'h152;
    #1;
    chk("spec_f_pc", bus.f_pc, 64'h150);
    chk("spec_mp", 64'(bus.mispredict), 64'd1);
    step();
    bus.M_icode = 4'h1; bus.W_icode = 4'h1;
    #1;
    chk("spec_unhalt", 64'(bus.halted), 64'd0);
    chk("spec_next", bus.f_pc, 64'h152);
    chk("spec_cnt2", 64'(bus.mispredict_cnt), 64'd2);

    set_mispredict(64'h160);
    step();
    chk("sat_cnt3", 64'(bus.mispredict_cnt), 64'd3);
    step();
    chk("sat_cnt_hold", 64'(bus.mispredict_cnt), 64'd3);
    bus.M_icode = 4'h1;

`ifdef BTFNT_PRED_EN
    bus.f_icode = 4'h7; bus.f_valC = 64'h80; bus.f_valP = 64'h90;
    #1;
    chk("btfnt_back", 64'(bus.f_pred_taken), 64'd1);
    bus.f_valC = 64'hA0;
    #1;
    chk("btfnt_fwd", 64'(bus.f_pred_taken), 64'd0);
    step();
    chk("btfnt_next", bus.f_pc, 64'h90);
`endif

    for (int i = 0; i < 3000; i++) begin
      step();
      rst_n            = ($urandom_range(0, 199) != 0);
      bus.f_icode      = rnd_icode();
      bus.f_valC       = {$urandom, $urandom};
      bus.f_valP       = {$urandom, $urandom};
      bus.F_stall      = ($urandom_range(0, 3) == 0);
      bus.M_icode      = ($urandom_range(0, 2) == 0) ? 4'h7 : 4'($urandom_range(1, 6));
      bus.M_cnd        = 1'($urandom_range(0, 1));
      bus.M_pred_taken = 1'($urandom_range(0, 1));
      bus.M_altPC      = {$urandom, $urandom};
      bus.W_icode      = ($urandom_range(0, 4) == 0) ? 4'h9 : 4'($urandom_range(1, 6));
      bus.W_valM       = {$urandom, $urandom};
    end
    step();
    rst_n = 1'b1;
    idle();
    repeat (2) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
